// File: rtl/ctrl_decode_stage_pkg.sv
// Shared definitions for the registered control decode stage.
//   - RV32I/M opcode constants and the funct7 value that marks MUL/DIV/REM
//   - result-source encodings driven on o_resultsrc
//   - issue FSM state type and the decoded control bundle
//   - max_int helper used to size the occupancy counter
package ctrl_decode_stage_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_U   = 7'b0110111;
    localparam logic [6:0] OP_UPC = 7'b0010111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [1:0] RESULTSRC_ALU    = 2'b00;
    localparam logic [1:0] RESULTSRC_LOAD   = 2'b01;
    localparam logic [1:0] RESULTSRC_PC4    = 2'b10;
    localparam logic [1:0] RESULTSRC_MULDIV = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } issue_state_t;

    typedef struct packed {
        logic       rf_wr;
        logic       selop1;
        logic       selop2;
        logic       branch;
        logic       load;
        logic       jal;
        logic       jalr;
        logic       wr_en;
        logic [1:0] resultsrc;
        logic       muldiv;
        logic [2:0] muldiv_op;
        logic       illegal;
    } ctrl_bundle_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational main decoder: opcode/funct3/funct7 -> control bundle.
// Ports:
//   opcode [6:0]  instruction bits [6:0]
//   funct3 [2:0]  instruction bits [14:12]
//   funct7 [6:0]  instruction bits [31:25]
//   ctrl          decoded control bundle (ctrl_bundle_t)
// Unknown opcodes, and M-extension ops when ENABLE_M=0, produce a bundle
// with only the illegal flag set so nothing downstream writes state.
module ctrl_decode_comb
    import ctrl_decode_stage_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output ctrl_bundle_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_R: begin
                if (funct7 == FUNCT7_MULDIV) begin
                    if (ENABLE_M != 0) begin
                        ctrl.rf_wr     = 1'b1;
                        ctrl.selop2    = 1'b1;
                        ctrl.resultsrc = RESULTSRC_MULDIV;
                        ctrl.muldiv    = 1'b1;
                        ctrl.muldiv_op = funct3;
                    end else begin
                        ctrl.illegal   = 1'b1;
                    end
                end else begin
                    ctrl.rf_wr  = 1'b1;
                    ctrl.selop2 = 1'b1;
                end
            end
            OP_I: begin
                ctrl.rf_wr = 1'b1;
            end
            OP_LD: begin
                ctrl.rf_wr     = 1'b1;
                ctrl.load      = 1'b1;
                ctrl.resultsrc = RESULTSRC_LOAD;
            end
            OP_S: begin
                ctrl.wr_en = 1'b1;
            end
            OP_B: begin
                ctrl.branch = 1'b1;
                ctrl.selop2 = 1'b1;
            end
            OP_J: begin
                ctrl.rf_wr     = 1'b1;
                ctrl.jal       = 1'b1;
                ctrl.resultsrc = RESULTSRC_PC4;
            end
            OP_JR: begin
                ctrl.rf_wr     = 1'b1;
                ctrl.selop1    = 1'b1;
                ctrl.jalr      = 1'b1;
                ctrl.resultsrc = RESULTSRC_PC4;
            end
            OP_U: begin
                ctrl.rf_wr = 1'b1;
            end
            OP_UPC: begin
                ctrl.rf_wr  = 1'b1;
                ctrl.selop1 = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage: decodes an RV32I/M instruction and registers the
// control bundle into the ID/EX boundary, with stall, flush and a small issue
// FSM that blocks acceptance while a MUL/DIV occupies the execute unit.
// Ports:
//   i_clk, i_rst      clock (rising edge), synchronous active-high reset
//   i_valid, i_instr  instruction offer
//   o_ready           stage can accept this cycle
//   i_stall           hold every output register
//   i_flush           kill the output stage and any multi-cycle op
//   o_valid           registered bundle valid
//   o_rf_wr .. o_wr_en, o_resultsrc, o_muldiv, o_muldiv_op, o_illegal
//                     registered control bundle
//   o_busy            issue FSM is in BUSY (exposes FSM state)
//
// Handshake: an instruction is taken on a rising edge where i_valid and
// o_ready are both high; o_ready is combinational (~busy & ~i_stall &
// ~i_flush) and never depends on i_valid. The taken bundle appears with
// o_valid=1 one cycle later. The output side has no back-pressure input;
// i_stall is the only way to hold it.
module ctrl_decode_stage
    import ctrl_decode_stage_pkg::*;
#(
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 34
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_instr,
    output logic        o_ready,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic        o_valid,
    output logic        o_rf_wr,
    output logic        o_selop1,
    output logic        o_selop2,
    output logic        o_branch,
    output logic        o_load,
    output logic        o_jal,
    output logic        o_jalr,
    output logic        o_wr_en,
    output logic [1:0]  o_resultsrc,
    output logic        o_muldiv,
    output logic [2:0]  o_muldiv_op,
    output logic        o_illegal,
    output logic        o_busy
);

    localparam int MAX_CYCLES = max_int(MUL_CYCLES, DIV_CYCLES);
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    // The counter is loaded with N-1: BUSY lasts exactly N-1 cycles.
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    ctrl_bundle_t  dec;
    ctrl_bundle_t  bundle_q;
    logic          valid_q;
    issue_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] load_val;
    logic          busy;
    logic          accept;
    logic          need_busy;
    logic          unused_instr_bits;

    ctrl_decode_comb #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .opcode (i_instr[6:0]),
        .funct3 (i_instr[14:12]),
        .funct7 (i_instr[31:25]),
        .ctrl   (dec)
    );

    // Register specifiers and immediates are not used by the control decode.
    assign unused_instr_bits = ^{i_instr[24:15], i_instr[11:7]};

    assign busy    = (state_q == ST_BUSY);
    assign o_ready = ~busy & ~i_stall & ~i_flush;
    assign accept  = i_valid & o_ready;

    // funct3[2] separates DIV/REM (long) from MUL* (short).
    assign load_val  = dec.muldiv_op[2] ? DIV_LOAD : MUL_LOAD;
    assign need_busy = dec.muldiv & (load_val != '0);

    // Issue FSM: the counter keeps running under stall; only flush aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && need_busy) begin
                        state_d = ST_BUSY;
                        cnt_d   = load_val;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output stage. Accept can only happen with stall and flush low, so the
    // order below is flush > stall > accept > bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (i_flush) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (i_stall) begin
            valid_q  <= valid_q;
            bundle_q <= bundle_q;
        end else if (accept) begin
            valid_q  <= 1'b1;
            bundle_q <= dec;
        end else begin
            // Bubble: only the state-writing enables need to be safe.
            valid_q        <= 1'b0;
            bundle_q.rf_wr <= 1'b0;
            bundle_q.wr_en <= 1'b0;
        end
    end

    assign o_valid     = valid_q;
    assign o_rf_wr     = bundle_q.rf_wr;
    assign o_selop1    = bundle_q.selop1;
    assign o_selop2    = bundle_q.selop2;
    assign o_branch    = bundle_q.branch;
    assign o_load      = bundle_q.load;
    assign o_jal       = bundle_q.jal;
    assign o_jalr      = bundle_q.jalr;
    assign o_wr_en     = bundle_q.wr_en;
    assign o_resultsrc = bundle_q.resultsrc;
    assign o_muldiv    = bundle_q.muldiv;
    assign o_muldiv_op = bundle_q.muldiv_op;
    assign o_illegal   = bundle_q.illegal;
    assign o_busy      = busy;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: directed scenarios plus a randomized run
// checked against a rule-based reference model. Three instances share the
// stimulus: default parameters (main), ENABLE_M=0, and 1/2-cycle M ops.
module tb_ctrl_decode_stage;

    localparam int MUL_N = 3;
    localparam int DIV_N = 34;

    localparam logic [31:0] I_ADD = 32'h003100B3;
    localparam logic [31:0] I_SW  = 32'h0020A023;
    localparam logic [31:0] I_JAL = 32'h008000EF;
    localparam logic [31:0] I_MUL = 32'h023100B3;
    localparam logic [31:0] I_DIV = 32'h023140B3;

    typedef struct packed {
        logic       valid;
        logic       rf_wr;
        logic       selop1;
        logic       selop2;
        logic       branch;
        logic       load;
        logic       jal;
        logic       jalr;
        logic       wr_en;
        logic [1:0] resultsrc;
        logic       muldiv;
        logic [2:0] muldiv_op;
        logic       illegal;
    } bundle_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid;
    logic [31:0] instr;
    logic        stall;
    logic        flush;

    int n_vec = 0;
    int n_err = 0;

    logic d_ready, d_valid, d_rf_wr, d_selop1, d_selop2, d_branch, d_load;
    logic d_jal, d_jalr, d_wr_en, d_muldiv, d_illegal, d_busy;
    logic [1:0] d_resultsrc;
    logic [2:0] d_muldiv_op;

    logic n_ready, n_valid, n_rf_wr, n_selop1, n_selop2, n_branch, n_load;
    logic n_jal, n_jalr, n_wr_en, n_muldiv, n_illegal, n_busy;
    logic [1:0] n_resultsrc;
    logic [2:0] n_muldiv_op;

    logic f_ready, f_valid, f_rf_wr, f_selop1, f_selop2, f_branch, f_load;
    logic f_jal, f_jalr, f_wr_en, f_muldiv, f_illegal, f_busy;
    logic [1:0] f_resultsrc;
    logic [2:0] f_muldiv_op;

    bundle_t d_obs, n_obs, f_obs;
    assign d_obs = {d_valid, d_rf_wr, d_selop1, d_selop2, d_branch, d_load, d_jal,
                    d_jalr, d_wr_en, d_resultsrc, d_muldiv, d_muldiv_op, d_illegal};
    assign n_obs = {n_valid, n_rf_wr, n_selop1, n_selop2, n_branch, n_load, n_jal,
                    n_jalr, n_wr_en, n_resultsrc, n_muldiv, n_muldiv_op, n_illegal};
    assign f_obs = {f_valid, f_rf_wr, f_selop1, f_selop2, f_branch, f_load, f_jal,
                    f_jalr, f_wr_en, f_resultsrc, f_muldiv, f_muldiv_op, f_illegal};

    ctrl_decode_stage #(.ENABLE_M(1), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_instr(instr), .o_ready(d_ready),
        .i_stall(stall), .i_flush(flush), .o_valid(d_valid), .o_rf_wr(d_rf_wr),
        .o_selop1(d_selop1), .o_selop2(d_selop2), .o_branch(d_branch), .o_load(d_load),
        .o_jal(d_jal), .o_jalr(d_jalr), .o_wr_en(d_wr_en), .o_resultsrc(d_resultsrc),
        .o_muldiv(d_muldiv), .o_muldiv_op(d_muldiv_op), .o_illegal(d_illegal), .o_busy(d_busy)
    );

    ctrl_decode_stage #(.ENABLE_M(0), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut_nom (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_instr(instr), .o_ready(n_ready),
        .i_stall(stall), .i_flush(flush), .o_valid(n_valid), .o_rf_wr(n_rf_wr),
        .o_selop1(n_selop1), .o_selop2(n_selop2), .o_branch(n_branch), .o_load(n_load),
        .o_jal(n_jal), .o_jalr(n_jalr), .o_wr_en(n_wr_en), .o_resultsrc(n_resultsrc),
        .o_muldiv(n_muldiv), .o_muldiv_op(n_muldiv_op), .o_illegal(n_illegal), .o_busy(n_busy)
    );

    ctrl_decode_stage #(.ENABLE_M(1), .MUL_CYCLES(1), .DIV_CYCLES(2)) dut_fast (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_instr(instr), .o_ready(f_ready),
        .i_stall(stall), .i_flush(flush), .o_valid(f_valid), .o_rf_wr(f_rf_wr),
        .o_selop1(f_selop1), .o_selop2(f_selop2), .o_branch(f_branch), .o_load(f_load),
        .o_jal(f_jal), .o_jalr(f_jalr), .o_wr_en(f_wr_en), .o_resultsrc(f_resultsrc),
        .o_muldiv(f_muldiv), .o_muldiv_op(f_muldiv_op), .o_illegal(f_illegal), .o_busy(f_busy)
    );

    // ---------------- reference model ----------------
    // Decode written from the opcode-class rules rather than a per-opcode table.
    function automatic bundle_t ref_decode(input logic [31:0] ins, input bit en_m);
        bundle_t    b;
        logic [6:0] op;
        bit         legal;
        bit         is_m;
        b     = '0;
        op    = ins[6:0];
        legal = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        is_m  = (op == 7'b0110011) && (ins[31:25] == 7'b0000001);
        b.valid = 1'b1;
        if (!legal || (is_m && !en_m)) begin
            b.illegal = 1'b1;
            return b;
        end
        b.rf_wr     = !(op inside {7'b1100011, 7'b0100011});
        b.selop1    = op inside {7'b0010111, 7'b1100111};
        b.selop2    = op inside {7'b0110011, 7'b1100011};
        b.branch    = (op == 7'b1100011);
        b.load      = (op == 7'b0000011);
        b.jal       = (op == 7'b1101111);
        b.jalr      = (op == 7'b1100111);
        b.wr_en     = (op == 7'b0100011);
        b.resultsrc = (op inside {7'b1101111, 7'b1100111}) ? 2'b10 :
                      (op == 7'b0000011) ? 2'b01 : is_m ? 2'b11 : 2'b00;
        b.muldiv    = is_m;
        b.muldiv_op = is_m ? ins[14:12] : 3'b000;
        return b;
    endfunction

    function automatic int ref_cycles(input logic [31:0] ins);
        return ins[14] ? DIV_N : MUL_N;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          r;
        ins = $urandom;
        r   = $urandom_range(0, 11);
        case (r)
            0, 1: begin ins[6:0] = 7'b0110011; ins[31:25] = 7'b0000001; end
            2:  ins[6:0] = 7'b0110011;
            3:  ins[6:0] = 7'b0010011;
            4:  ins[6:0] = 7'b0000011;
            5:  ins[6:0] = 7'b0100011;
            6:  ins[6:0] = 7'b1100011;
            7:  ins[6:0] = 7'b1101111;
            8:  ins[6:0] = 7'b1100111;
            9:  ins[6:0] = 7'b0110111;
            10: ins[6:0] = 7'b0010111;
            default: ;
        endcase
        return ins;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic v, input logic [31:0] ins, input logic st, input logic fl);
        valid = v;
        instr = ins;
        stall = st;
        flush = fl;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts cycles with o_ready low on the main instance (inputs idle).
    task automatic count_busy(input string tag, output int low);
        low = 0;
        #1;
        while (d_ready !== 1'b1) begin
            if (low >= 100) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_timeout ready still low after %0d cycles (required high)", tag, low);
                return;
            end
            low++;
            cyc();
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) cyc();
        n_vec++;
        if ({d_obs, d_busy, n_obs, n_busy, f_obs, f_busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got d=%h/%b n=%h f=%h required all 0",
                     d_obs, d_busy, n_obs, f_obs);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (d_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready got %b required 1", d_ready);
        end
        cyc();
    endtask

    task automatic test_add();
        int low;
        set_in(1'b1, I_ADD, 1'b0, 1'b0);
        #1;
        n_vec++;
        if (d_ready !== 1'b1) begin
            n_err++;
            $display("FAIL add_ready_before got %b required 1", d_ready);
        end
        cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++;
        if ({d_valid, d_rf_wr, d_selop2, d_resultsrc, d_illegal, d_wr_en} !== 7'b1_1_1_00_0_0) begin
            n_err++;
            $display("FAIL add_bundle got %b required 1110000",
                     {d_valid, d_rf_wr, d_selop2, d_resultsrc, d_illegal, d_wr_en});
        end
        count_busy("add", low);
        n_vec++;
        if (low !== 0) begin
            n_err++;
            $display("FAIL add_ready_after got %0d low cycles required 0", low);
        end
        cyc();
        n_vec++;
        if ({d_valid, d_rf_wr, d_wr_en} !== 3'b000) begin
            n_err++;
            $display("FAIL add_bubble got %b required 000", {d_valid, d_rf_wr, d_wr_en});
        end
    endtask

    task automatic test_back_to_back();
        set_in(1'b1, I_SW, 1'b0, 1'b0);
        cyc();
        set_in(1'b1, I_JAL, 1'b0, 1'b0);
        n_vec++;
        if ({d_valid, d_rf_wr, d_wr_en, d_selop2} !== 4'b1010) begin
            n_err++;
            $display("FAIL sw_bundle got %b required 1010", {d_valid, d_rf_wr, d_wr_en, d_selop2});
        end
        cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++;
        if ({d_valid, d_jal, d_rf_wr, d_resultsrc, d_wr_en} !== 6'b1_1_1_10_0) begin
            n_err++;
            $display("FAIL jal_bundle got %b required 111100",
                     {d_valid, d_jal, d_rf_wr, d_resultsrc, d_wr_en});
        end
    endtask

    task automatic test_muldiv();
        int low;
        set_in(1'b1, I_MUL, 1'b0, 1'b0);
        cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++;
        if ({d_valid, d_muldiv, d_muldiv_op, d_resultsrc, d_rf_wr, d_busy} !== 9'b1_1_000_11_1_1) begin
            n_err++;
            $display("FAIL mul_bundle got %b required 110001111",
                     {d_valid, d_muldiv, d_muldiv_op, d_resultsrc, d_rf_wr, d_busy});
        end
        count_busy("mul", low);
        n_vec++;
        if (low !== MUL_N - 1) begin
            n_err++;
            $display("FAIL mul_ready_low got %0d cycles required %0d", low, MUL_N - 1);
        end
        cyc();
        set_in(1'b1, I_DIV, 1'b0, 1'b0);
        cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++;
        if ({d_muldiv, d_muldiv_op, d_busy} !== 5'b1_100_1) begin
            n_err++;
            $display("FAIL div_bundle got %b required 11001", {d_muldiv, d_muldiv_op, d_busy});
        end
        count_busy("div", low);
        n_vec++;
        if (low !== DIV_N - 1) begin
            n_err++;
            $display("FAIL div_ready_low got %0d cycles required %0d", low, DIV_N - 1);
        end
        cyc();
    endtask

    task automatic test_illegal();
        int low;
        set_in(1'b1, 32'h0000_0000, 1'b0, 1'b0);
        cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++;
        if ({d_valid, d_illegal, d_rf_wr, d_wr_en, d_branch, d_load, d_jal, d_jalr, d_muldiv}
            !== 9'b1_1_0000000) begin
            n_err++;
            $display("FAIL illegal_zero got %b required 110000000",
                     {d_valid, d_illegal, d_rf_wr, d_wr_en, d_branch, d_load, d_jal, d_jalr, d_muldiv});
        end
        cyc();
        set_in(1'b1, I_MUL, 1'b0, 1'b0);
        cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        n_vec++;
        if ({n_valid, n_illegal, n_muldiv, n_rf_wr, n_wr_en, n_busy, n_ready} !== 7'b1100001) begin
            n_err++;
            $display("FAIL nom_mul_illegal got %b required 1100001",
                     {n_valid, n_illegal, n_muldiv, n_rf_wr, n_wr_en, n_busy, n_ready});
        end
        count_busy("illegal_drain", low);
        cyc();
    endtask

    task automatic test_flush();
        set_in(1'b1, I_DIV, 1'b0, 1'b0);
        cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (4) cyc();
        // fifth busy cycle: flush while also offering an instruction
        set_in(1'b1, I_ADD, 1'b0, 1'b1);
        #1;
        n_vec++;
        if (d_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready_during got %b required 0", d_ready);
        end
        cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        n_vec++;
        if ({d_busy, d_valid, d_rf_wr, d_wr_en, d_illegal, d_muldiv, d_ready} !== 7'b0000001) begin
            n_err++;
            $display("FAIL flush_busy got %b required 0000001",
                     {d_busy, d_valid, d_rf_wr, d_wr_en, d_illegal, d_muldiv, d_ready});
        end
        cyc();
        set_in(1'b1, I_ADD, 1'b0, 1'b1);
        cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++;
        if ({d_valid, d_rf_wr} !== 2'b00) begin
            n_err++;
            $display("FAIL flush_beats_valid got %b required 00", {d_valid, d_rf_wr});
        end
    endtask

    task automatic test_stall();
        bundle_t exp_b;
        exp_b = ref_decode(I_ADD, 1'b1);
        set_in(1'b1, I_ADD, 1'b0, 1'b0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, I_SW, 1'b1, 1'b0);
            #1;
            n_vec++;
            if (d_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_ready k=%0d got %b required 0", k, d_ready);
            end
            cyc();
            n_vec++;
            if (d_obs !== exp_b) begin
                n_err++;
                $display("FAIL stall_hold k=%0d got %h required %h", k, d_obs, exp_b);
            end
        end
        // busy counter keeps running under stall
        set_in(1'b1, I_MUL, 1'b0, 1'b0);
        cyc();
        set_in(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (MUL_N - 1) cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        n_vec++;
        if ({d_busy, d_ready, d_muldiv} !== 3'b011) begin
            n_err++;
            $display("FAIL stall_counter got %b required 011", {d_busy, d_ready, d_muldiv});
        end
        cyc();
    endtask

    task automatic test_reset_busy();
        set_in(1'b1, I_DIV, 1'b0, 1'b0);
        cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        n_vec++;
        if ({d_obs, d_busy} !== '0) begin
            n_err++;
            $display("FAIL reset_busy got %h/%b required all 0", d_obs, d_busy);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (d_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_busy_ready got %b required 1", d_ready);
        end
        cyc();
    endtask

    task automatic test_single_cycle();
        int low;
        set_in(1'b1, I_MUL, 1'b0, 1'b0);
        cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        n_vec++;
        if ({f_valid, f_muldiv, f_busy, f_ready} !== 4'b1101) begin
            n_err++;
            $display("FAIL n1_mul got %b required 1101", {f_valid, f_muldiv, f_busy, f_ready});
        end
        count_busy("n1_drain_a", low);
        cyc();
        set_in(1'b1, I_DIV, 1'b0, 1'b0);
        cyc();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        n_vec++;
        if ({f_busy, f_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL n2_div_busy got %b required 10", {f_busy, f_ready});
        end
        cyc();
        #1;
        n_vec++;
        if ({f_busy, f_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL n2_div_done got %b required 01", {f_busy, f_ready});
        end
        count_busy("n1_drain_b", low);
        cyc();
    endtask

    task automatic test_random();
        bundle_t m_cur;
        bundle_t mask;
        bit      m_full;
        bit      m_flushed;
        int      busy_left;
        rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        rst       = 1'b0;
        m_cur     = '0;
        m_full    = 1'b1;
        m_flushed = 1'b0;
        busy_left = 0;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ins;
            bit          v, st, fl, exp_rdy;
            ins = rand_instr();
            v   = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 9) == 0);
            fl  = ($urandom_range(0, 24) == 0);
            set_in(v, ins, st, fl);
            #1;
            exp_rdy = (busy_left == 0) && !st && !fl;
            n_vec++;
            if (d_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL rand_ready i=%0d got %b required %b", i, d_ready, exp_rdy);
            end
            @(posedge clk);
            if (fl) begin
                m_cur.valid   = 1'b0;
                m_cur.rf_wr   = 1'b0;
                m_cur.wr_en   = 1'b0;
                m_cur.illegal = 1'b0;
                m_cur.muldiv  = 1'b0;
                m_full        = 1'b0;
                m_flushed     = 1'b1;
                busy_left     = 0;
            end else if (st) begin
                if (busy_left > 0) busy_left--;
            end else if (v && busy_left == 0) begin
                m_cur     = ref_decode(ins, 1'b1);
                m_full    = 1'b1;
                m_flushed = 1'b0;
                busy_left = m_cur.muldiv ? ref_cycles(ins) - 1 : 0;
            end else begin
                m_cur.valid = 1'b0;
                m_cur.rf_wr = 1'b0;
                m_cur.wr_en = 1'b0;
                m_full      = 1'b0;
                m_flushed   = 1'b0;
                if (busy_left > 0) busy_left--;
            end
            @(negedge clk);
            mask       = '0;
            mask.valid = 1'b1;
            mask.rf_wr = 1'b1;
            mask.wr_en = 1'b1;
            if (m_flushed) begin
                mask.illegal = 1'b1;
                mask.muldiv  = 1'b1;
            end
            if (m_full) begin
                mask = '1;
                if (!m_cur.muldiv) mask.muldiv_op = 3'b000;
                if (m_cur.illegal) begin
                    mask.selop1    = 1'b0;
                    mask.selop2    = 1'b0;
                    mask.resultsrc = 2'b00;
                end
            end
            n_vec++;
            if (((d_obs & mask) !== (m_cur & mask)) || (d_busy !== (busy_left > 0))) begin
                n_err++;
                $display("FAIL rand_bundle i=%0d instr=%h got %h busy=%b required %h busy=%b mask=%h",
                         i, ins, d_obs, d_busy, m_cur, (busy_left > 0), mask);
            end
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_add();
        test_back_to_back();
        test_muldiv();
        test_illegal();
        test_flush();
        test_stall();
        test_reset_busy();
        test_single_cycle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
Registered, parametrised successor to the combinational main decoder. Decodes a 32-bit RV32I/M instruction into the standard control bundle and registers it into the ID/EX boundary with a valid/ready handshake, stall and flush. Adds M-extension decode, illegal-opcode detection, and a multi-cycle issue FSM that throttles acceptance while a MUL/DIV occupies the execute unit.

Parameters:
ENABLE_M, 1, 1 = decode MUL/DIV/REM (funct7=0000001 on R opcode); 0 = treat them as illegal
MUL_CYCLES, 3, execute occupancy of MUL* ops in cycles (>=1)
DIV_CYCLES, 34, execute occupancy of DIV*/REM* ops in cycles (>=1)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  instruction present on i_instr
i_instr  in  32  instruction word
o_ready  out  1  accepting this cycle; comb = ~busy & ~i_stall & ~i_flush
i_stall  in  1  hold all output registers
i_flush  in  1  kill output stage and any multi-cycle op
o_valid  out  1  registered bundle valid
o_rf_wr, o_selop1, o_selop2, o_branch, o_load, o_jal, o_jalr, o_wr_en  out  1 each  control bits (mapping below)
o_resultsrc  out  2  00 ALU, 01 load, 10 PC+4, 11 muldiv
o_muldiv  out  1  M-extension op
o_muldiv_op  out  3  funct3 of M op
o_illegal  out  1  unknown opcode / disabled M op
o_busy  out  1  multi-cycle FSM not IDLE

Behaviour:
- Decode (same mapping as the existing decoder): rf_wr=0 for B,S else 1; selop1=1 for UPC,JR; selop2=1 for R,B; load for LD; branch for B; jal for J; jalr for JR; wr_en for S; resultsrc=10 for J/JR, 01 for LD, 11 for M op, else 00.
- Legal opcodes: R, I(0010011), LD, S, B, J, JR, U(0110111), UPC. Anything else -> illegal=1 and rf_wr, wr_en, branch, load, jal, jalr, muldiv all 0. R with funct7=0000001 when ENABLE_M=0 -> illegal with the same zeroing.
- Accept = i_valid & o_ready. On accept, the decoded bundle is registered with o_valid=1 and is visible the next cycle (latency 1).
- No accept, no stall, no flush: o_valid<=0; control registers are don't-care except that rf_wr and wr_en are forced to 0.
- i_stall=1 (no flush): all output registers hold. The FSM counter still decrements.
- i_flush=1: next cycle o_valid=0, rf_wr=0, wr_en=0, illegal=0, muldiv=0, FSM->IDLE. Flush beats stall and beats a simultaneous i_valid (no accept).
- FSM states IDLE, BUSY:
  - IDLE->BUSY on accept of an M op when its cycle count N>1 (N=MUL_CYCLES for funct3[2]=0, DIV_CYCLES for funct3[2]=1). Counter loads N-1.
  - BUSY decrements each cycle and returns to IDLE when the counter reaches 1. o_ready is therefore low for exactly N-1 cycles after the accept.
  - If N=1, the FSM stays IDLE.
- Counter width is $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
- Reset: all outputs 0, FSM IDLE, counter 0. o_ready=1 the cycle after reset if stall and flush are low. Reset mid-BUSY aborts the op.

Decomposition:
- parameters.vh holds the opcode constants (R, I, LD, S, B, J, JR, U, UPC), the new FUNCT7_MULDIV, and the RESULTSRC_* encodings.
- Sub-module: keep a pure combinational decode function/module ctrl_decode_comb (opcode, funct3, funct7 -> bundle). The stage wrapper owns the registers and FSM.

Test Plan:
- Reset then 0x003100B3 (ADD) with i_valid=1 -> next cycle o_valid=1, rf_wr=1, selop2=1, resultsrc=00, illegal=0; o_ready stays 1.
- 0x0020A023 (SW) -> rf_wr=0, wr_en=1, selop2=0. Then 0x008000EF (JAL) -> jal=1, rf_wr=1, resultsrc=10.
- 0x023100B3 (MUL), MUL_CYCLES=3 -> o_muldiv=1, muldiv_op=000, resultsrc=11. o_ready low for 2 cycles with o_busy=1, then high. Follow with 0x023140B3 (DIV), DIV_CYCLES=34 -> o_ready low for 33 cycles.
- 0x00000000 -> o_illegal=1, rf_wr=0, wr_en=0. Repeat with ENABLE_M=0 and 0x023100B3 -> o_illegal=1, o_muldiv=0.
- DIV accepted, then i_flush at busy cycle 5 -> next cycle o_busy=0, o_valid=0, o_ready=1. i_flush with i_valid=1 -> no accept, o_valid=0.
- i_stall held 3 cycles after an ADD accept -> bundle unchanged, o_ready=0. Assert i_rst during BUSY -> all outputs 0 next cycle.
